// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one Simple Bus register slave between two requesters.
// Optional per-requester saturating grant counters when ARB_GRANT_CNT_EN is defined.
module simple_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
`ifdef ARB_GRANT_CNT_EN
   ,
   parameter int unsigned CNT_WIDTH  = 16
`endif
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESET,
   input  logic                  m0_valid,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ready,
   output logic                  m0_done,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_valid,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ready,
   output logic                  m1_done,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH-1:0] wrAddr,
   output logic [DATA_WIDTH-1:0] wrData,
   output logic                  wr,
   output logic [ADDR_WIDTH-1:0] rdAddr,
   input  logic [DATA_WIDTH-1:0] rdData,
   output logic                  rd
`ifdef ARB_GRANT_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  m0_grant_cnt,
   output logic [CNT_WIDTH-1:0]  m1_grant_cnt
`endif
);

   typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

   state_e                state_q;
   logic                  last_grant_q;
   logic                  cmd_sel_q;
   logic                  cmd_we_q;
   logic                  sel;
   logic                  accept;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      sel = 1'b0;
      if (m1_valid && !m0_valid) begin
         sel = 1'b1;
      end else if (m1_valid && m0_valid) begin
         sel = ~last_grant_q;
      end
   end

   assign m0_ready  = (state_q == StIdle) & m0_valid & ~sel;
   assign m1_ready  = (state_q == StIdle) & m1_valid & sel;
   assign accept    = m0_ready | m1_ready;
   assign sel_we    = sel ? m1_we    : m0_we;
   assign sel_addr  = sel ? m1_addr  : m0_addr;
   assign sel_wdata = sel ? m1_wdata : m0_wdata;

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         cmd_sel_q    <= 1'b0;
         cmd_we_q     <= 1'b0;
         wr           <= 1'b0;
         rd           <= 1'b0;
         wrAddr       <= '0;
         wrData       <= '0;
         rdAddr       <= '0;
         m0_done      <= 1'b0;
         m1_done      <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  cmd_sel_q    <= sel;
                  cmd_we_q     <= sel_we;
                  last_grant_q <= sel;
                  wr           <= sel_we;
                  rd           <= ~sel_we;
                  if (sel_we) begin
                     wrAddr <= sel_addr;
                     wrData <= sel_wdata;
                  end else begin
                     rdAddr <= sel_addr;
                  end
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               wr     <= 1'b0;
               rd     <= 1'b0;
               wrAddr <= '0;
               wrData <= '0;
               rdAddr <= '0;
               // Slave read data is combinational on rd/rdAddr, so capture it here.
               if (!cmd_we_q) begin
                  if (cmd_sel_q) begin
                     m1_rdata <= rdData;
                  end else begin
                     m0_rdata <= rdData;
                  end
               end
               m0_done <= ~cmd_sel_q;
               m1_done <= cmd_sel_q;
               state_q <= StDone;
            end
            StDone: begin
               m0_done <= 1'b0;
               m1_done <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef ARB_GRANT_CNT_EN
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         m0_grant_cnt <= '0;
         m1_grant_cnt <= '0;
      end else begin
         if (m0_ready && (m0_grant_cnt != {CNT_WIDTH{1'b1}})) begin
            m0_grant_cnt <= m0_grant_cnt + 1'b1;
         end
         if (m1_ready && (m1_grant_cnt != {CNT_WIDTH{1'b1}})) begin
            m1_grant_cnt <= m1_grant_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Scoreboard bench for simple_bus_arbiter with a small register-slave model.
// Counter checks are compiled only when ARB_GRANT_CNT_EN is defined.
module tb_simple_bus_arbiter;

   typedef struct packed {
      logic        m;
      logic        we;
      logic [5:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        S_AXI_ACLK;
   logic        S_AXI_ARESET;
   logic        m0_valid, m0_we, m0_ready, m0_done;
   logic [5:0]  m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_valid, m1_we, m1_ready, m1_done;
   logic [5:0]  m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic [5:0]  wrAddr, rdAddr;
   logic [31:0] wrData, rdData;
   logic        wr, rd;
`ifdef ARB_GRANT_CNT_EN
   logic [1:0]  m0_grant_cnt, m1_grant_cnt;
`endif

   int          checks_total  = 0;
   int          checks_passed = 0;
   int          strobe_cnt    = 0;
   exp_t        sq[$];
   exp_t        dq[$];
   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];
   logic        mem_loaded = 1'b0;

   simple_bus_arbiter #(
      .ADDR_WIDTH(6),
      .DATA_WIDTH(32)
`ifdef ARB_GRANT_CNT_EN
      ,
      .CNT_WIDTH(2)
`endif
   ) dut (
      .S_AXI_ACLK   (S_AXI_ACLK),
      .S_AXI_ARESET (S_AXI_ARESET),
      .m0_valid     (m0_valid),
      .m0_we        (m0_we),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_ready     (m0_ready),
      .m0_done      (m0_done),
      .m0_rdata     (m0_rdata),
      .m1_valid     (m1_valid),
      .m1_we        (m1_we),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_ready     (m1_ready),
      .m1_done      (m1_done),
      .m1_rdata     (m1_rdata),
      .wrAddr       (wrAddr),
      .wrData       (wrData),
      .wr           (wr),
      .rdAddr       (rdAddr),
      .rdData       (rdData),
      .rd           (rd)
`ifdef ARB_GRANT_CNT_EN
      ,
      .m0_grant_cnt (m0_grant_cnt),
      .m1_grant_cnt (m1_grant_cnt)
`endif
   );

   initial S_AXI_ACLK = 1'b0;
   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   // Register slave: writes land on the clock edge, reads are combinational.
   always @(posedge S_AXI_ACLK) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 16; i++) slv_mem[i] <= 32'hA5A5_0000 | i;
         slv_mem[1] <= 32'h1234_5678;
         mem_loaded <= 1'b1;
      end else if (wr) begin
         slv_mem[wrAddr[5:2]] <= wrData;
      end
   end
   assign rdData = rd ? slv_mem[rdAddr[5:2]] : 32'h0;

   // Monitor: every strobe and every done pulse is matched against the scoreboard.
   always @(negedge S_AXI_ACLK) begin : monitor
      exp_t e;
      logic ok;
      checks_total++;
      if (wr && rd) begin
         $display("FAIL strobe_excl: wr=%b rd=%b required not both", wr, rd);
      end else if (wr || rd) begin
         strobe_cnt++;
         if (sq.size() == 0) begin
            $display("FAIL strobe_unexpected: wr=%b rd=%b wrAddr=%h rdAddr=%h required none",
                     wr, rd, wrAddr, rdAddr);
         end else begin
            e  = sq.pop_front();
            ok = (wr === e.we) && (rd === !e.we);
            if (e.we) ok = ok && (wrAddr === e.addr) && (wrData === e.data) && (rdAddr === 6'h0);
            else      ok = ok && (rdAddr === e.addr) && (wrAddr === 6'h0) && (wrData === 32'h0);
            if (ok) checks_passed++;
            else $display("FAIL strobe: wr=%b rd=%b wrAddr=%h wrData=%h rdAddr=%h required we=%b addr=%h data=%h",
                          wr, rd, wrAddr, wrData, rdAddr, e.we, e.addr, e.data);
         end
      end else begin
         if ((wrAddr === 6'h0) && (rdAddr === 6'h0) && (wrData === 32'h0)) checks_passed++;
         else $display("FAIL bus_idle: wrAddr=%h wrData=%h rdAddr=%h required 0", wrAddr, wrData,
                       rdAddr);
      end
      if (m0_done || m1_done) begin
         checks_total++;
         if (dq.size() == 0) begin
            $display("FAIL done_unexpected: m0_done=%b m1_done=%b required none", m0_done, m1_done);
         end else begin
            e  = dq.pop_front();
            ok = (m0_done === !e.m) && (m1_done === e.m);
            if (!e.we) ok = ok && ((e.m ? m1_rdata : m0_rdata) === e.data);
            if (ok) checks_passed++;
            else $display("FAIL done: m0_done=%b m1_done=%b m0_rdata=%h m1_rdata=%h required m%0d rdata=%h",
                          m0_done, m1_done, m0_rdata, m1_rdata, e.m, e.data);
         end
      end
   end

   // Expectations are pushed in predicted grant order; reads take data from ref_mem.
   task automatic expect_cmd(input logic m, input logic we, input logic [5:0] a,
                             input logic [31:0] d);
      exp_t e;
      e.m = m; e.we = we; e.addr = a; e.data = d;
      sq.push_back(e);
      if (we) ref_mem[a[5:2]] = d;
      else e.data = ref_mem[a[5:2]];
      dq.push_back(e);
   endtask

   task automatic m0_cmd(input logic we, input logic [5:0] a, input logic [31:0] d);
      int n;
      n = 0;
      m0_valid = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
      @(negedge S_AXI_ACLK);
      while (!m0_ready && n < 60) begin
         n++;
         @(negedge S_AXI_ACLK);
      end
      checks_total++;
      if (m0_ready) checks_passed++;
      else $display("FAIL m0_accept_timeout: ready=%b required 1", m0_ready);
      @(posedge S_AXI_ACLK);
      #1 m0_valid = 1'b0;
   endtask

   task automatic m1_cmd(input logic we, input logic [5:0] a, input logic [31:0] d);
      int n;
      n = 0;
      m1_valid = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
      @(negedge S_AXI_ACLK);
      while (!m1_ready && n < 60) begin
         n++;
         @(negedge S_AXI_ACLK);
      end
      checks_total++;
      if (m1_ready) checks_passed++;
      else $display("FAIL m1_accept_timeout: ready=%b required 1", m1_ready);
      @(posedge S_AXI_ACLK);
      #1 m1_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      S_AXI_ARESET = 1'b1;
      @(posedge S_AXI_ACLK);
      #1 S_AXI_ARESET = 1'b0;
   endtask

   task automatic test_reset();
      S_AXI_ARESET = 1'b1;
      m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      repeat (2) @(posedge S_AXI_ACLK);
      #1;
      checks_total++;
      if ({wr, rd, wrAddr, rdAddr, wrData} === '0 && {m0_done, m1_done} === 2'b00) checks_passed++;
      else $display("FAIL reset_bus: wr=%b rd=%b wrAddr=%h rdAddr=%h wrData=%h done=%b%b required 0",
                    wr, rd, wrAddr, rdAddr, wrData, m0_done, m1_done);
      checks_total++;
      if (m0_rdata === 32'h0 && m1_rdata === 32'h0 && !m0_ready && !m1_ready) checks_passed++;
      else $display("FAIL reset_req: m0_rdata=%h m1_rdata=%h ready=%b%b required 0",
                    m0_rdata, m1_rdata, m0_ready, m1_ready);
      S_AXI_ARESET = 1'b0;
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic test_write_latency();
      expect_cmd(1'b0, 1'b1, 6'h00, 32'hDEAD_BEEF);
      m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 6'h00; m0_wdata = 32'hDEAD_BEEF;
      @(negedge S_AXI_ACLK);
      checks_total++;
      if (m0_ready === 1'b1 && m1_ready === 1'b0) checks_passed++;
      else $display("FAIL wr_ready_T: ready=%b%b required m0=1 m1=0", m0_ready, m1_ready);
      @(posedge S_AXI_ACLK);
      #1 m0_valid = 1'b0;
      @(negedge S_AXI_ACLK);
      checks_total++;
      if (wr === 1'b1 && rd === 1'b0 && wrAddr === 6'h00 && wrData === 32'hDEAD_BEEF) checks_passed++;
      else $display("FAIL wr_strobe_T1: wr=%b rd=%b wrAddr=%h wrData=%h required 1 0 00 deadbeef",
                    wr, rd, wrAddr, wrData);
      @(negedge S_AXI_ACLK);
      checks_total++;
      if (m0_done === 1'b1 && m1_done === 1'b0 && m1_ready === 1'b0) checks_passed++;
      else $display("FAIL wr_done_T2: m0_done=%b m1_done=%b required 1 0", m0_done, m1_done);
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic test_read_latency();
      expect_cmd(1'b1, 1'b0, 6'h04, 32'h0);
      m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 6'h04; m1_wdata = 32'h0;
      @(negedge S_AXI_ACLK);
      checks_total++;
      if (m1_ready === 1'b1 && m0_ready === 1'b0) checks_passed++;
      else $display("FAIL rd_ready_T: ready=%b%b required m0=0 m1=1", m0_ready, m1_ready);
      @(posedge S_AXI_ACLK);
      #1 m1_valid = 1'b0;
      @(negedge S_AXI_ACLK);
      checks_total++;
      if (rd === 1'b1 && wr === 1'b0 && rdAddr === 6'h04) checks_passed++;
      else $display("FAIL rd_strobe_T1: rd=%b wr=%b rdAddr=%h required 1 0 04", rd, wr, rdAddr);
      @(negedge S_AXI_ACLK);
      checks_total++;
      if (m1_done === 1'b1 && m0_done === 1'b0 && m1_rdata === 32'h1234_5678) checks_passed++;
      else $display("FAIL rd_done_T2: m1_done=%b m0_done=%b m1_rdata=%h required 1 0 12345678",
                    m1_done, m0_done, m1_rdata);
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic test_back_to_back();
      int base;
      int win;
      pulse_reset();
      // m1 reads back what m0 just wrote, so the data also proves the alternation.
      for (int i = 0; i < 4; i++) begin
         expect_cmd(1'b0, 1'b1, 6'(6'h10 + 4 * i), 32'hB0B0_0000 + i);
         expect_cmd(1'b1, 1'b0, 6'(6'h10 + 4 * i), 32'h0);
      end
      base = strobe_cnt;
      win  = 0;
      fork
         for (int i = 0; i < 4; i++) m0_cmd(1'b1, 6'(6'h10 + 4 * i), 32'hB0B0_0000 + i);
         for (int j = 0; j < 4; j++) m1_cmd(1'b0, 6'(6'h10 + 4 * j), 32'h0);
         begin
            repeat (24) @(posedge S_AXI_ACLK);
            win = strobe_cnt - base;
         end
      join
      checks_total++;
      if (win == 8) checks_passed++;
      else $display("FAIL b2b_strobes_24cyc: got %0d required 8", win);
      #1;
   endtask

   task automatic test_fairness();
      expect_cmd(1'b0, 1'b1, 6'h20, 32'hF000_0001);
      expect_cmd(1'b1, 1'b0, 6'h20, 32'h0);
      expect_cmd(1'b0, 1'b1, 6'h24, 32'hF000_0002);
      expect_cmd(1'b0, 1'b1, 6'h28, 32'hF000_0003);
      expect_cmd(1'b0, 1'b1, 6'h2C, 32'hF000_0004);
      fork
         begin
            m0_cmd(1'b1, 6'h20, 32'hF000_0001);
            m0_cmd(1'b1, 6'h24, 32'hF000_0002);
            m0_cmd(1'b1, 6'h28, 32'hF000_0003);
            m0_cmd(1'b1, 6'h2C, 32'hF000_0004);
         end
         begin
            @(posedge S_AXI_ACLK);
            #1 m1_cmd(1'b0, 6'h20, 32'h0);
         end
      join
      repeat (3) @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   bad;
      e.m = 1'b0; e.we = 1'b1; e.addr = 6'h04; e.data = 32'hCAFE_F00D;
      sq.push_back(e);
      m0_cmd(1'b1, 6'h04, 32'hCAFE_F00D);
      @(negedge S_AXI_ACLK);
      #1 S_AXI_ARESET = 1'b1;
      #1;
      checks_total++;
      if (wr === 1'b0 && wrAddr === 6'h0 && wrData === 32'h0) checks_passed++;
      else $display("FAIL rst_mid_async: wr=%b wrAddr=%h wrData=%h required 0", wr, wrAddr, wrData);
      @(posedge S_AXI_ACLK);
      #1 S_AXI_ARESET = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge S_AXI_ACLK);
         if (m0_done !== 1'b0 || m1_done !== 1'b0) bad++;
      end
      checks_total++;
      if (bad == 0) checks_passed++;
      else $display("FAIL rst_mid_no_done: %0d done cycles required 0", bad);
      @(posedge S_AXI_ACLK);
      #1;
      expect_cmd(1'b0, 1'b0, 6'h04, 32'h0);
      expect_cmd(1'b1, 1'b0, 6'h08, 32'h0);
      fork
         m0_cmd(1'b0, 6'h04, 32'h0);
         m1_cmd(1'b0, 6'h08, 32'h0);
         begin
            @(negedge S_AXI_ACLK);
            checks_total++;
            if (m0_ready === 1'b1 && m1_ready === 1'b0) checks_passed++;
            else $display("FAIL rst_mid_tie: ready=%b%b required m0=1 m1=0", m0_ready, m1_ready);
         end
      join
      repeat (3) @(posedge S_AXI_ACLK);
      #1;
   endtask

`ifdef ARB_GRANT_CNT_EN
   task automatic test_grant_cnt();
      logic [1:0] exp_cnt;
      pulse_reset();
      checks_total++;
      if (m0_grant_cnt === 2'd0 && m1_grant_cnt === 2'd0) checks_passed++;
      else $display("FAIL cnt_reset: m0=%0d m1=%0d required 0 0", m0_grant_cnt, m1_grant_cnt);
      for (int i = 0; i < 5; i++) begin
         expect_cmd(1'b0, 1'b1, 6'h30, 32'hC000_0000 + i);
         m0_cmd(1'b1, 6'h30, 32'hC000_0000 + i);
         exp_cnt = (i < 2) ? 2'(i + 1) : 2'd3;
         checks_total++;
         if (m0_grant_cnt === exp_cnt && m1_grant_cnt === 2'd0) checks_passed++;
         else $display("FAIL cnt_sat[%0d]: m0=%0d m1=%0d required %0d 0", i, m0_grant_cnt,
                       m1_grant_cnt, exp_cnt);
      end
      repeat (3) @(posedge S_AXI_ACLK);
      #1;
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 | i;
      ref_mem[1] = 32'h1234_5678;
      test_reset();
      test_write_latency();
      test_read_latency();
      test_back_to_back();
      test_fairness();
      test_reset_mid();
`ifdef ARB_GRANT_CNT_EN
      test_grant_cnt();
`endif
      repeat (4) @(negedge S_AXI_ACLK);
      checks_total++;
      if (sq.size() == 0 && dq.size() == 0) checks_passed++;
      else $display("FAIL scoreboard_drain: strobes=%0d dones=%0d outstanding required 0 0",
                    sq.size(), dq.size());
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
